// File: rtl/fifo_uart_tx_if.sv
// Byte-FIFO read side plus UART serial outputs for fifo_uart_tx.
// The transmitter plugs in through the slave modport; the environment uses master.
interface fifo_uart_tx_if;
    logic       tx_en;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic [7:0] tx_count;

    modport master (
        output tx_en,
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_en,
        input  tx,
        input  busy,
        input  tx_count
    );

    modport slave (
        input  tx_en,
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_en,
        output tx,
        output busy,
        output tx_count
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that pops bytes from an upstream registered-read FIFO.
// Every output comes straight from a flop, computed from the next-state values.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic          clk,
    input  logic          rst,
    fifo_uart_tx_if.slave bus
);
    localparam int unsigned BAUD_W = 16;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_POP   = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);

    logic [2:0]        state_q,  state_d;
    logic [BAUD_W-1:0] baud_q,   baud_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q,  shift_d;
    logic              tx_q,     tx_d;
    logic              rd_en_q,  rd_en_d;
    logic              busy_q,   busy_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              bit_done_c;

    assign bit_done_c = (baud_q == BAUD_LAST);

    // Next-state logic; the baud counter restarts at zero on every bit boundary.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q + BAUD_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        count_d   = count_q;

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (bus.tx_en && !bus.fifo_empty) begin
                    state_d = S_POP;
                end
            end
            S_POP: begin
                baud_d  = '0;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                baud_d  = '0;
                shift_d = bus.fifo_data;
                state_d = S_START;
            end
            S_START: begin
                if (bit_done_c) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done_c) begin
                    baud_d = '0;
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        shift_d   = {1'b0, shift_q[DATA_W-1:1]};
                    end
                end
            end
            S_STOP: begin
                if (bit_done_c) begin
                    baud_d  = '0;
                    count_d = count_q + CNT_W'(1);
                    state_d = S_IDLE;
                end
            end
            default: begin
                baud_d  = '0;
                state_d = S_IDLE;
            end
        endcase

        // Line level for the coming cycle: LSB of the shifter carries the current data bit.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase

        rd_en_d = (state_d == S_POP);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            rd_en_q   <= rd_en_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.fifo_rd_en = rd_en_q;
    assign bus.busy       = busy_q;
    assign bus.tx_count   = count_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: per-cycle check against a frame-offset timing model
// plus directed literal checks on decoded serial bytes and pop spacing.
module tb_fifo_uart_tx;
    localparam int C     = 4;
    localparam int FRAME = 10 * C + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_uart_tx_if ifc ();

    fifo_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int vectors = 0;
    int errors  = 0;

    // Environment FIFO and model state: m_k is the cycle offset from the POP cycle, -1 when idle.
    logic [7:0] q[$];
    int         m_k    = -1;
    int         m_cnt  = 0;
    logic [7:0] m_byte = 8'h00;

    bit txlog[$];
    int rdlog[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        errors++;
        $display("FAIL %s @%0t: bound expired", name, $time);
    endtask

    function automatic logic exp_tx(input int k, input logic [7:0] b);
        int seg;
        if (k < 2) return 1'b1;
        seg = (k - 2) / C;
        if (seg == 0) return 1'b0;
        if (seg <= 8) return b[seg-1];
        return 1'b1;
    endfunction

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        ifc.fifo_empty = 1'b0;
    endtask

    task automatic clear_logs();
        txlog.delete();
        rdlog.delete();
    endtask

    // One clock: advance model from pre-edge inputs, serve FIFO read, compare all outputs.
    task automatic tick();
        logic       rd_pre;
        int         nk;
        int         ncnt;
        logic [7:0] nb;
        logic [10:0] e;
        logic [10:0] a;
        rd_pre = ifc.fifo_rd_en;
        nk   = m_k;
        ncnt = m_cnt;
        nb   = m_byte;
        if (rst) begin
            nk   = -1;
            ncnt = 0;
        end else if (m_k >= 0) begin
            if (m_k == FRAME - 1) begin
                nk   = -1;
                ncnt = (m_cnt + 1) % 256;
            end else begin
                nk = m_k + 1;
            end
        end else if (ifc.tx_en && q.size() != 0) begin
            nk = 0;
            nb = q[0];
        end
        @(posedge clk);
        #1;
        if (rd_pre && q.size() != 0) ifc.fifo_data = q.pop_front();
        ifc.fifo_empty = (q.size() == 0);
        m_k    = nk;
        m_cnt  = ncnt;
        m_byte = nb;
        if (ifc.fifo_rd_en) rdlog.push_back(txlog.size());
        txlog.push_back(ifc.tx);
        e = {exp_tx(m_k, m_byte), (m_k >= 0), (m_k == 0), 8'(m_cnt)};
        a = {ifc.tx, ifc.busy, ifc.fifo_rd_en, ifc.tx_count};
        check("cycle{tx,busy,rd,cnt}", 32'(a), 32'(e));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifc.tx_en = 1'b0;
        q.delete();
        ifc.fifo_empty = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_idle(input int bound);
        int n = 0;
        while (!(m_k == -1 && (q.size() == 0 || !ifc.tx_en)) && n < bound) begin
            tick();
            n++;
        end
        if (!(m_k == -1 && (q.size() == 0 || !ifc.tx_en))) fail_now("run_idle");
    endtask

    task automatic wait_k(input int k, input int bound);
        int n = 0;
        while (m_k != k && n < bound) begin
            tick();
            n++;
        end
        if (m_k != k) fail_now("wait_k");
    endtask

    function automatic bit decode(input int from, output logic [7:0] b, output int nxt);
        b   = 8'h00;
        nxt = from;
        for (int s = from; s < txlog.size(); s++) begin
            if (txlog[s] == 1'b0) begin
                if (s + 9 * C >= txlog.size()) return 1'b0;
                for (int i = 0; i < 8; i++) b[i] = txlog[s + C * (i + 1) + C / 2];
                nxt = s + 10 * C;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    initial begin
        logic [7:0] dec;
        logic [7:0] exp3[3];
        int         pos;
        int         nxt;
        int         pushed;
        int         s0;
        bit         ok;
        exp3[0] = 8'h00;
        exp3[1] = 8'hFF;
        exp3[2] = 8'h3C;

        ifc.tx_en      = 1'b0;
        ifc.fifo_empty = 1'b1;
        ifc.fifo_data  = 8'h00;

        // Reset values
        do_reset();
        check("rst_tx", 32'(ifc.tx), 32'd1);
        check("rst_busy", 32'(ifc.busy), 32'd0);
        check("rst_rd", 32'(ifc.fifo_rd_en), 32'd0);
        check("rst_cnt", 32'(ifc.tx_count), 32'd0);

        // Single byte 0xA5
        clear_logs();
        push(8'hA5);
        ifc.tx_en = 1'b1;
        run_idle(200);
        tick();
        ok = decode(0, dec, nxt);
        check("a5_found", 32'(ok), 32'd1);
        check("a5_byte", 32'(dec), 32'hA5);
        s0 = nxt - 10 * C;
        if (s0 >= 0 && s0 + C < txlog.size()) begin
            check("a5_start_last_low", 32'(txlog[s0 + C - 1]), 32'd0);
            check("a5_bit0_high", 32'(txlog[s0 + C]), 32'd1);
        end
        check("a5_pops", 32'(rdlog.size()), 32'd1);
        check("a5_cnt", 32'(ifc.tx_count), 32'd1);

        // Three queued bytes back to back
        do_reset();
        clear_logs();
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        ifc.tx_en = 1'b1;
        run_idle(500);
        tick();
        pos = 0;
        for (int i = 0; i < 3; i++) begin
            ok = decode(pos, dec, nxt);
            check("q3_found", 32'(ok), 32'd1);
            check("q3_byte", 32'(dec), 32'(exp3[i]));
            pos = nxt;
        end
        check("q3_pops", 32'(rdlog.size()), 32'd3);
        if (rdlog.size() == 3) begin
            check("q3_gap01", 32'(rdlog[1] - rdlog[0]), 32'd43);
            check("q3_gap12", 32'(rdlog[2] - rdlog[1]), 32'd43);
        end
        check("q3_cnt", 32'(ifc.tx_count), 32'd3);
        check("q3_busy_low", 32'(ifc.busy), 32'd0);

        // tx_en gating
        do_reset();
        clear_logs();
        push(8'h81);
        repeat (20) tick();
        check("gate_no_pop", 32'(rdlog.size()), 32'd0);
        check("gate_tx_idle", 32'(ifc.tx), 32'd1);
        ifc.tx_en = 1'b1;
        tick();
        check("gate_pop_next", 32'(ifc.fifo_rd_en), 32'd1);
        push(8'h5A);
        wait_k(2 + 2 * C, 100);
        ifc.tx_en = 1'b0;
        run_idle(200);
        repeat (20) tick();
        check("gate_one_pop", 32'(rdlog.size()), 32'd1);
        check("gate_cnt", 32'(ifc.tx_count), 32'd1);
        ok = decode(0, dec, nxt);
        check("gate_byte", 32'(dec), 32'h81);

        // Reset during the third data bit of 0x55
        do_reset();
        clear_logs();
        push(8'h55);
        ifc.tx_en = 1'b1;
        wait_k(2 + 3 * C, 100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_tx", 32'(ifc.tx), 32'd1);
        check("midrst_busy", 32'(ifc.busy), 32'd0);
        check("midrst_cnt", 32'(ifc.tx_count), 32'd0);
        clear_logs();
        repeat (20) tick();
        check("midrst_quiet_tx", 32'(ifc.tx), 32'd1);
        check("midrst_no_pop", 32'(rdlog.size()), 32'd0);

        // Random traffic with random tx_en and occasional reset
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (q.size() < 8 && $urandom_range(0, 3) == 0) push(8'($urandom));
            ifc.tx_en = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;

        // 256 frames wrap the counter
        do_reset();
        clear_logs();
        pushed = 0;
        for (int n = 0; n < 20000; n++) begin
            if (pushed == 256 && m_k == -1 && q.size() == 0) break;
            if (pushed < 256 && q.size() < 8 && $urandom_range(0, 1) == 0) begin
                push(8'($urandom));
                pushed++;
            end
            ifc.tx_en = ($urandom_range(0, 9) != 0);
            tick();
        end
        if (!(pushed == 256 && m_k == -1 && q.size() == 0)) fail_now("wrap_run");
        tick();
        check("wrap_cnt", 32'(ifc.tx_count), 32'd0);
        check("wrap_pops", 32'(rdlog.size()), 32'd256);
        ifc.tx_en = 1'b1;
        repeat (50) tick();
        check("empty_no_pop", 32'(rdlog.size()), 32'd256);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per UART bit period; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 tx_en  input  1  1 = frames may be launched; 0 = no new frame starts, a frame in flight completes.
REQ-005 fifo_empty  input  1  empty flag from the upstream 8-deep byte FIFO.
REQ-006 fifo_data  input  8  FIFO read data; valid on the cycle after a cycle with fifo_rd_en=1.
REQ-007 fifo_rd_en  output  1  FIFO pop request, one-cycle pulse per byte.
REQ-008 tx  output  1  UART serial line, 8N1, idle high.
REQ-009 busy  output  1  1 whenever state is not IDLE.
REQ-010 tx_count  output  8  bytes fully transmitted since reset, modulo 256.

Function
REQ-011 The FSM SHALL have states IDLE, POP, LOAD, START, DATA, STOP.
REQ-012 IDLE: tx=1; if tx_en=1 and fifo_empty=0, SHALL go to POP next cycle, else stay.
REQ-013 POP: fifo_rd_en=1 for exactly this one cycle; SHALL go to LOAD unconditionally.
REQ-014 LOAD: shift register SHALL capture fifo_data at end of this cycle; go to START; tx stays 1.
REQ-015 fifo_rd_en SHALL be 0 in every state other than POP (one pop per frame, never two back-to-back).
REQ-016 START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA.
REQ-017 DATA: 8 bits, LSB first, each held exactly CLKS_PER_BIT cycles; 3-bit bit index 0..7; after bit 7 go to STOP.
REQ-018 STOP: tx=1 for exactly CLKS_PER_BIT cycles; on last cycle tx_count increments (8-bit wrap 255->0) and FSM returns to IDLE.
REQ-019 Baud counter SHALL be 16 bits, reloaded to 0 on every bit boundary and state entry; no cycle drift between bits.
REQ-020 tx SHALL be driven from a register (glitch-free); tx=1 in IDLE, POP, LOAD.
REQ-021 Frame occupancy: POP(1)+LOAD(1)+10*CLKS_PER_BIT cycles; back-to-back frames SHALL have exactly 1 IDLE cycle between STOP end and next POP (stop bit effectively 10*CLKS_PER_BIT+3 cycles per byte including IDLE/POP/LOAD high time).
REQ-022 tx_en deassert during POP..STOP SHALL NOT abort the frame; it only blocks the IDLE->POP transition.
REQ-023 fifo_empty changes outside IDLE SHALL be ignored.
REQ-024 fifo_data SHALL be sampled only in LOAD; its value in other cycles is don't-care.

Reset
REQ-025 With rst=1 at a clock edge: state=IDLE, tx=1, fifo_rd_en=0, busy=0, tx_count=0, baud counter=0, bit index=0, shift register=0.
REQ-026 Reset mid-frame SHALL abort immediately; tx=1 on the cycle after the reset edge; the partially sent byte is lost and not counted.
REQ-027 If rst=1 in POP, the popped byte is lost; no retry.

Verification (CLKS_PER_BIT=4)
REQ-028 Reset: rst=1 two cycles -> tx=1, busy=0, fifo_rd_en=0, tx_count=0.
REQ-029 Single byte 0xA5, FIFO model with registered read: tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 each 4 cycles, stop 4 cycles high; exactly one fifo_rd_en pulse; tx_count=1.
REQ-030 Three bytes 0x00,0xFF,0x3C queued, tx_en=1: decoded serial stream equals input order; fifo_rd_en pulses exactly 3 times, spaced 43 cycles; tx_count=3; busy falls after last stop bit.
REQ-031 tx_en=0 with FIFO non-empty for 20 cycles -> no fifo_rd_en, tx=1; raise tx_en -> POP on next cycle; drop tx_en during DATA -> frame completes, no further pop.
REQ-032 rst asserted on 3rd data bit of 0x55 -> next cycle tx=1, busy=0, tx_count unchanged; after release with FIFO empty, tx stays 1.
REQ-033 256 single-byte frames -> tx_count wraps to 0; fifo_empty=1 throughout IDLE -> fifo_rd_en never asserted.
